// File: rtl/envelope_gen.sv
// envelope_gen: per-oscillator segmented amplitude envelope.
// Walks ENV_LEN gain/duration segments one sample at a time, holds after
// SUSTAIN_SEG while the gate is high, and drives a registered amplitude word.
// Optional feature macro: ENVGEN_VELOCITY_EN. When defined, amp is the
// velocity-scaled gain ((velocity * env_gain) >> 8); when undefined there is
// no multiplier and amp = {env_gain, 24'h0}.
module envelope_gen #(
    parameter int ENV_LEN     = 8,
    parameter int SUSTAIN_SEG = 2,
    parameter int DUR_W       = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         sample_en,
    input  logic [ENV_LEN*8-1:0]         gains,
    input  logic [ENV_LEN*DUR_W-1:0]     durations,
    input  logic [31:0]                  velocity,
    input  logic                         trig,
    input  logic                         gate,
    output logic [7:0]                   env_gain,
    output logic [31:0]                  amp,
    output logic [$clog2(ENV_LEN)-1:0]   seg,
    output logic                         active
);

    localparam int SEG_W = $clog2(ENV_LEN);
    localparam logic [SEG_W-1:0] SUS_SEG  = SEG_W'(SUSTAIN_SEG);
    localparam logic [SEG_W-1:0] REL_SEG  = SEG_W'(SUSTAIN_SEG + 1);
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(ENV_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SUSTAIN} state_t;

    state_t           state_q;
    logic [SEG_W-1:0] seg_q;
    logic [DUR_W-1:0] cnt_q;
    logic [7:0]       env_q;
    logic             active_q;
    logic             trig_q1;
    logic             trig_pend_q;
    logic [31:0]      amp_q;
    logic [31:0]      amp_d;
    logic [7:0]       tgt;
    logic [DUR_W-1:0] dur;

    // Select the live gain/duration pair of the current segment.
    always_comb begin
        // NOTE: defaults first so every path assigns; otherwise a latch is inferred.
        tgt = '0;
        dur = '0;
        for (int j = 0; j < ENV_LEN; j++) begin
            if (seg_q == SEG_W'(j)) begin
                tgt = gains[8*j +: 8];
                dur = durations[DUR_W*j +: DUR_W];
            end
        end
    end

    // Catch a rising edge of trig and hold it until the next sample strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_q1     <= 1'b0;
            trig_pend_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            trig_q1     <= trig;
            trig_pend_q <= (trig_pend_q & ~sample_en) | (trig & ~trig_q1);
        end
    end

    // Envelope state machine; advances only on sample strobes.
    // Priority: pending trigger, then gate release, then normal stepping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            seg_q    <= '0;
            cnt_q    <= '0;
            env_q    <= '0;
            active_q <= 1'b0;
        end else if (sample_en) begin
            if (trig_pend_q) begin
                // Restart from segment 0 but keep the current gain to avoid a click.
                state_q  <= ST_RUN;
                seg_q    <= '0;
                cnt_q    <= '0;
                active_q <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        active_q <= 1'b0;
                    end
                    ST_SUSTAIN: begin
                        if (!gate) begin
                            state_q <= ST_RUN;
                            seg_q   <= REL_SEG;
                            cnt_q   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (!gate && (seg_q <= SUS_SEG)) begin
                            // Early release: jump to the release segment from the current gain.
                            seg_q <= REL_SEG;
                            cnt_q <= '0;
                        end else if ((dur == '0) || (env_q == tgt)) begin
                            if (dur == '0) begin
                                env_q <= tgt;
                            end
                            cnt_q <= '0;
                            if ((seg_q == SUS_SEG) && gate) begin
                                state_q <= ST_SUSTAIN;
                            end else if (seg_q == LAST_SEG) begin
                                state_q  <= ST_IDLE;
                                active_q <= 1'b0;
                            end else begin
                                seg_q <= seg_q + SEG_W'(1);
                            end
                        end else if (cnt_q == (dur - DUR_W'(1))) begin
                            cnt_q <= '0;
                            env_q <= (env_q < tgt) ? env_q + 8'd1 : env_q - 8'd1;
                        end else begin
                            cnt_q <= cnt_q + DUR_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef ENVGEN_VELOCITY_EN
    logic [39:0] prod;
    logic        unused_prod_lsb;
    assign prod            = {8'd0, velocity} * {32'd0, env_q};
    assign amp_d           = prod[39:8];
    assign unused_prod_lsb = ^prod[7:0];
`else
    logic unused_velocity;
    assign amp_d           = {env_q, 24'h0};
    assign unused_velocity = ^velocity;
`endif

    // Register the amplitude word one clock behind the envelope gain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            amp_q <= '0;
        end else begin
            amp_q <= amp_d;
        end
    end

    assign env_gain = env_q;
    assign amp      = amp_q;
    assign seg      = seg_q;
    assign active   = active_q;

endmodule

// File: tb/tb_envelope_gen.sv
// tb_envelope_gen: directed scoreboard bench for envelope_gen.
// Expected values are pushed before each sample strobe and popped/compared
// once the DUT has produced its outputs.
module tb_envelope_gen;

    localparam int ENV_LEN = 8;
    localparam int DUR_W   = 8;

    logic                     clk       = 1'b0;
    logic                     rstn      = 1'b0;
    logic                     sample_en = 1'b0;
    logic                     trig      = 1'b0;
    logic                     gate      = 1'b0;
    logic [ENV_LEN*8-1:0]     gains     = '0;
    logic [ENV_LEN*DUR_W-1:0] durations = '0;
    logic [31:0]              velocity  = 32'h8000_0000;
    logic [7:0]               env_gain;
    logic [31:0]              amp;
    logic [2:0]               seg;
    logic                     active;

    int compared   = 0;
    int mismatched = 0;

    typedef enum int {K_ENV, K_AMP, K_SEG, K_ACT} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    envelope_gen #(
        .ENV_LEN    (ENV_LEN),
        .SUSTAIN_SEG(2),
        .DUR_W      (DUR_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sample_en(sample_en),
        .gains    (gains),
        .durations(durations),
        .velocity (velocity),
        .trig     (trig),
        .gate     (gate),
        .env_gain (env_gain),
        .amp      (amp),
        .seg      (seg),
        .active   (active)
    );

    always #5 clk = ~clk;

    // Amplitude expected from a settled gain value.
    function automatic logic [31:0] exp_amp(input logic [7:0] e);
`ifdef ENVGEN_VELOCITY_EN
        logic [39:0] p;
        p = {8'd0, velocity} * {32'd0, e};
        return p[39:8];
`else
        return {e, 24'h0};
`endif
    endfunction

    task automatic push(input string tag, input kind_t kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic push_state(input string tag, input logic [7:0] e, input logic [2:0] s,
                              input logic a);
        push({tag, ".env"}, K_ENV, {24'd0, e});
        push({tag, ".amp"}, K_AMP, exp_amp(e));
        push({tag, ".seg"}, K_SEG, {29'd0, s});
        push({tag, ".act"}, K_ACT, {31'd0, a});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_ENV:   obs = {24'd0, env_gain};
                K_AMP:   obs = amp;
                K_SEG:   obs = {29'd0, seg};
                default: obs = {31'd0, active};
            endcase
            compared++;
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // One sample strobe; with settle=1 also wait a clock so amp has caught up.
    task automatic sample(input bit settle);
        @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        if (settle) @(negedge clk);
        drain();
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic set_seg(input int j, input logic [7:0] g, input logic [7:0] d);
        gains[8*j +: 8]         = g;
        durations[DUR_W*j +: 8] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        gains     = '0;
        durations = '0;
        gate      = 1'b0;
        trig      = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        push_state("reset", 8'd0, 3'd0, 1'b0);
        drain();
        @(negedge clk);
        rstn = 1'b1;
        push_state("idle_no_trig", 8'd0, 3'd0, 1'b0);
        sample(1'b1);

        // Attack ramp: one LSB every second sample up to 4
        set_seg(0, 8'd4, 8'd2);
        set_seg(1, 8'd4, 8'd0);
        gate = 1'b1;
        pulse_trig();
        push_state("atk_start", 8'd0, 3'd0, 1'b1);
        sample(1'b1);
        for (int k = 1; k <= 8; k++) begin
            push_state($sformatf("atk_s%0d", k), 8'(k / 2), 3'd0, 1'b1);
            sample(1'b1);
        end
        push_state("atk_adv", 8'd4, 3'd1, 1'b1);
        sample(1'b1);

        // Asynchronous reset mid-run
        @(negedge clk);
        rstn = 1'b0;
        #1;
        push_state("async_rst", 8'd0, 3'd0, 1'b0);
        drain();
        @(negedge clk);
        rstn = 1'b1;
        gate = 1'b0;
        push_state("post_rst_idle", 8'd0, 3'd0, 1'b0);
        sample(1'b1);

        // Sustain / release with zero durations
        gains     = '0;
        durations = '0;
        set_seg(0, 8'd8, 8'd0);
        set_seg(1, 8'd4, 8'd0);
        set_seg(2, 8'd4, 8'd0);
        gate = 1'b1;
        pulse_trig();
        push_state("sus_s1", 8'd0, 3'd0, 1'b1); sample(1'b1);
        push_state("sus_s2", 8'd8, 3'd1, 1'b1); sample(1'b1);
        push_state("sus_s3", 8'd4, 3'd2, 1'b1); sample(1'b1);
        push_state("sus_hold1", 8'd4, 3'd2, 1'b1); sample(1'b1);
        push_state("sus_hold2", 8'd4, 3'd2, 1'b1); sample(1'b1);
        gate = 1'b0;
        push_state("rel_s3", 8'd4, 3'd3, 1'b1); sample(1'b1);
        push_state("rel_s4", 8'd0, 3'd4, 1'b1); sample(1'b1);
        push_state("rel_s5", 8'd0, 3'd5, 1'b1); sample(1'b1);
        push_state("rel_s6", 8'd0, 3'd6, 1'b1); sample(1'b1);
        push_state("rel_s7", 8'd0, 3'd7, 1'b1); sample(1'b1);
        push_state("rel_idle", 8'd0, 3'd7, 1'b0); sample(1'b1);
        push_state("rel_idle2", 8'd0, 3'd7, 1'b0); sample(1'b1);

        // Early release from segment 0 at gain 3
        do_reset();
        set_seg(0, 8'd10, 8'd1);
        set_seg(3, 8'd0, 8'd1);
        gate = 1'b1;
        pulse_trig();
        push_state("er_s1", 8'd0, 3'd0, 1'b1); sample(1'b1);
        push_state("er_s2", 8'd1, 3'd0, 1'b1); sample(1'b1);
        push_state("er_s3", 8'd2, 3'd0, 1'b1); sample(1'b1);
        push_state("er_s4", 8'd3, 3'd0, 1'b1); sample(1'b1);
        gate = 1'b0;
        push_state("er_jump", 8'd3, 3'd3, 1'b1); sample(1'b1);
        push_state("er_r2", 8'd2, 3'd3, 1'b1); sample(1'b1);
        push_state("er_r1", 8'd1, 3'd3, 1'b1); sample(1'b1);
        push_state("er_r0", 8'd0, 3'd3, 1'b1); sample(1'b1);
        push_state("er_adv", 8'd0, 3'd4, 1'b1); sample(1'b1);

        // Retrigger and gate fall on the same sample: trigger wins
        do_reset();
        set_seg(0, 8'd10, 8'd1);
        gate = 1'b1;
        pulse_trig();
        push_state("rt_s1", 8'd0, 3'd0, 1'b1); sample(1'b1);
        push_state("rt_s2", 8'd1, 3'd0, 1'b1); sample(1'b1);
        push_state("rt_s3", 8'd2, 3'd0, 1'b1); sample(1'b1);
        @(negedge clk);
        trig = 1'b1;
        gate = 1'b0;
        @(negedge clk);
        trig = 1'b0;
        push_state("rt_trig_wins", 8'd2, 3'd0, 1'b1); sample(1'b1);
        push_state("rt_then_rel", 8'd2, 3'd3, 1'b1); sample(1'b1);

        // Amplitude latency and velocity scaling at full gain
        do_reset();
        velocity = 32'h8000_0000;
        set_seg(0, 8'd255, 8'd0);
        set_seg(1, 8'd255, 8'd0);
        gate = 1'b1;
        pulse_trig();
        push_state("vel_s1", 8'd0, 3'd0, 1'b1); sample(1'b1);
        push("vel_env", K_ENV, 32'd255);
        push("vel_amp_lag", K_AMP, 32'd0);
        push("vel_seg", K_SEG, 32'd1);
        sample(1'b0);
        @(negedge clk);
`ifdef ENVGEN_VELOCITY_EN
        push("vel_amp", K_AMP, 32'h7F80_0000);
`else
        push("vel_amp", K_AMP, 32'hFF00_0000);
`endif
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
